// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit-entry slice.
// Optional clamp feature in keypad_digit_entry is selected with SEC_CLAMP_EN.
package keypad_pkg;

    localparam int unsigned BCD_W        = 4;
    localparam int unsigned KEYS         = 10;
    localparam int unsigned MAX_DIGIT    = 9;
    localparam int unsigned SEC_TENS_MAX = 5;

    // Any non-digit code decodes to an all-zero key image.
    localparam logic [BCD_W-1:0] KEY_NONE = '1;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        ENTRY,
        LOAD
    } state_e;

    function automatic logic is_digit(input logic [BCD_W-1:0] code);
        return code <= BCD_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_to_onehot.sv
// Combinational BCD digit to 10-bit one-hot key image; codes above 9 give zero.
module bcd_to_onehot
    import keypad_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [KEYS-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (is_digit(i_bcd)) begin
            o_onehot[i_bcd] = 1'b1;
        end
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad receiver: edge-detects held keys into an MM:SS entry buffer and pulses load on start.
// Build option: define SEC_CLAMP_EN to clamp seconds above 59 to 59 on the load cycle.
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MIN_HOLD   = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [BCD_W-1:0] i_bcd,
    input  logic             i_valid_data,
    input  logic             i_start,
    input  logic             i_clear_entry,
    output logic [BCD_W-1:0] o_sec_ones,
    output logic [BCD_W-1:0] o_sec_tens,
    output logic [BCD_W-1:0] o_min_ones,
    output logic [BCD_W-1:0] o_min_tens,
    output logic [2:0]       o_digit_count,
    output logic             o_entry_full,
    output logic             o_load,
    output logic [KEYS-1:0]  o_key_onehot
);

    localparam logic [2:0] CountMax = 3'(NUM_DIGITS);
    localparam logic [7:0] HoldLim  = 8'(MIN_HOLD);

    state_e                             r_state, w_state_next;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]   r_dig, w_dig_next;
    logic [2:0]                         r_count, w_count_next;
    logic [BCD_W-1:0]                   r_key, w_key_next;
    logic [7:0]                         r_rel, w_rel_next;
    logic                               w_key_event;
    logic                               w_start_ok;

    assign w_key_event = i_valid_data && is_digit(i_bcd)
                         && (r_state == IDLE || r_state == ENTRY);
    assign w_start_ok  = (r_state == HELD || r_state == ENTRY) && (r_count != 3'd0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_dig   <= '0;
            r_count <= '0;
            r_key   <= KEY_NONE;
            r_rel   <= '0;
        end else begin
            r_state <= w_state_next;
            r_dig   <= w_dig_next;
            r_count <= w_count_next;
            r_key   <= w_key_next;
            r_rel   <= w_rel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dig_next   = r_dig;
        w_count_next = r_count;
        w_key_next   = r_key;
        w_rel_next   = '0;
        if (i_clear_entry || r_state == LOAD) begin
            w_state_next = IDLE;
            w_dig_next   = '0;
            w_count_next = '0;
            w_key_next   = KEY_NONE;
        end else if (i_start) begin
            // start outranks a simultaneous key; with an empty buffer it is simply dropped
            if (w_start_ok) begin
                w_state_next = LOAD;
            end
        end else begin
            unique case (r_state)
                IDLE, ENTRY: begin
                    if (w_key_event) begin
                        w_state_next = HELD;
                        if (r_count < CountMax) begin
                            w_dig_next   = {r_dig[NUM_DIGITS-2:0], i_bcd};
                            w_count_next = r_count + 3'd1;
                            w_key_next   = i_bcd;
                        end
                    end
                end
                HELD: begin
                    if (!i_valid_data) begin
                        if (r_rel + 8'd1 >= HoldLim) begin
                            w_state_next = ENTRY;
                        end else begin
                            w_rel_next = r_rel + 8'd1;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_load        = (r_state == LOAD);
        o_sec_ones    = r_dig[0];
        o_sec_tens    = r_dig[1];
        o_min_ones    = r_dig[2];
        o_min_tens    = r_dig[3];
        o_digit_count = r_count;
        o_entry_full  = (r_count == CountMax);
`ifdef SEC_CLAMP_EN
        // For valid BCD, a tens digit above 5 is exactly a seconds value above 59.
        if (r_state == LOAD && r_dig[1] > BCD_W'(SEC_TENS_MAX)) begin
            o_sec_tens = BCD_W'(SEC_TENS_MAX);
            o_sec_ones = BCD_W'(MAX_DIGIT);
        end
`endif
    end

    bcd_to_onehot u_key_dec (
        .i_bcd    (r_key),
        .o_onehot (o_key_onehot)
    );

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry; honours SEC_CLAMP_EN for the clamp case.
module tb_keypad_digit_entry;

    typedef struct {
        string       name;
        logic [30:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_bcd = 4'd0;
    logic       i_valid_data = 1'b0;
    logic       i_start = 1'b0;
    logic       i_clear_entry = 1'b0;
    logic [3:0] o_sec_ones, o_sec_tens, o_min_ones, o_min_tens;
    logic [2:0] o_digit_count;
    logic       o_entry_full, o_load;
    logic [9:0] o_key_onehot;

    logic [3:0] dec_code = 4'd0;
    logic [9:0] dec_onehot;
    logic       snap_req = 1'b0;
    logic       dec_req = 1'b0;
    logic       done_req = 1'b0;

    exp_t load_q[$];
    exp_t snap_q[$];
    exp_t dec_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [9:0] OH0 = 10'b0000000001;
    localparam logic [9:0] OH4 = 10'b0000010000;
    localparam logic [9:0] OH5 = 10'b0000100000;
    localparam logic [9:0] OH6 = 10'b0001000000;
    localparam logic [9:0] OH7 = 10'b0010000000;

    always #5 clk = ~clk;

    keypad_digit_entry dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_bcd         (i_bcd),
        .i_valid_data  (i_valid_data),
        .i_start       (i_start),
        .i_clear_entry (i_clear_entry),
        .o_sec_ones    (o_sec_ones),
        .o_sec_tens    (o_sec_tens),
        .o_min_ones    (o_min_ones),
        .o_min_tens    (o_min_tens),
        .o_digit_count (o_digit_count),
        .o_entry_full  (o_entry_full),
        .o_load        (o_load),
        .o_key_onehot  (o_key_onehot)
    );

    bcd_to_onehot u_ref_dec (
        .i_bcd    (dec_code),
        .o_onehot (dec_onehot)
    );

    function automatic logic [30:0] mk(input logic [3:0] mt, input logic [3:0] mo,
                                       input logic [3:0] st, input logic [3:0] so,
                                       input logic [2:0] cnt, input logic full,
                                       input logic [9:0] oh, input logic ld);
        return {mt, mo, st, so, cnt, full, oh, ld};
    endfunction

    task automatic check(input string nm, input logic [30:0] act, input logic [30:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares whenever the DUT pulses load or a snapshot/decoder probe is presented.
    always @(negedge clk) begin
        logic [30:0] obs;
        exp_t        e;
        obs = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_digit_count,
               o_entry_full, o_key_onehot, o_load};
        if (o_load === 1'b1) begin
            if (load_q.size() == 0) begin
                check("unexpected_load", obs, 31'd0);
            end else begin
                e = load_q.pop_front();
                check(e.name, obs, e.val);
            end
        end
        if (snap_req) begin
            if (snap_q.size() == 0) begin
                check("snap_queue_empty", obs, 31'h7fffffff);
            end else begin
                e = snap_q.pop_front();
                check(e.name, obs, e.val);
            end
        end
        if (dec_req && dec_q.size() != 0) begin
            e = dec_q.pop_front();
            check(e.name, {21'd0, dec_onehot}, e.val);
        end
        if (done_req) begin
            check("load_queue_drained", 31'(load_q.size()), 31'd0);
            check("snap_queue_drained", 31'(snap_q.size()), 31'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm, input logic [30:0] v);
        snap_q.push_back('{nm, v});
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    task automatic press(input logic [3:0] d, input int hi, input int lo);
        i_bcd = d;
        i_valid_data = 1'b1;
        repeat (hi) step();
        i_valid_data = 1'b0;
        repeat (lo) step();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear_entry = 1'b1;
        step();
        i_clear_entry = 1'b0;
    endtask

    initial begin
        logic [9:0] one;
        one = 10'd1;
        step();
        for (int c = 0; c < 16; c++) begin
            dec_code = 4'(c);
            dec_q.push_back('{$sformatf("decoder_%0d", c), {21'd0, (c <= 9) ? (one << c) : 10'd0}});
            dec_req = 1'b1;
            step();
            dec_req = 1'b0;
        end

        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        snap("reset_state", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        press(4'd1, 3, 2);
        press(4'd2, 3, 2);
        press(4'd3, 3, 2);
        press(4'd4, 3, 2);
        snap("entry_1234", mk(1, 2, 3, 4, 4, 1, OH4, 0));
        load_q.push_back('{"load_1234", mk(1, 2, 3, 4, 4, 1, OH4, 1)});
        pulse_start();
        step();
        snap("after_load_1234", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        press(4'd7, 20, 2);
        snap("hold_7_once", mk(0, 0, 0, 7, 1, 0, OH7, 0));
        pulse_clear();

        press(4'd9, 3, 2);
        press(4'd8, 3, 2);
        press(4'd7, 3, 2);
        press(4'd6, 3, 2);
        press(4'd5, 3, 2);
        snap("fifth_dropped", mk(9, 8, 7, 6, 4, 1, OH6, 0));
        pulse_clear();
        snap("cleared_full", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        press(4'hC, 3, 2);
        snap("bad_code_ignored", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));
        pulse_start();
        step();
        step();
        snap("start_empty_no_load", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        press(4'd3, 3, 2);
        press(4'd2, 3, 2);
        i_clear_entry = 1'b1;
        i_start = 1'b1;
        step();
        i_clear_entry = 1'b0;
        i_start = 1'b0;
        step();
        snap("clear_beats_start", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        i_bcd = 4'd5;
        i_valid_data = 1'b1;
        step();
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        i_valid_data = 1'b0;
        snap("reset_mid_held", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));
        press(4'd4, 3, 2);
        snap("after_reset_press", mk(0, 0, 0, 4, 1, 0, OH4, 0));
        pulse_clear();

        press(4'd0, 3, 2);
        snap("zero_first_digit", mk(0, 0, 0, 0, 1, 0, OH0, 0));
        press(4'd7, 3, 2);
        press(4'd5, 3, 2);
        snap("entry_075", mk(0, 0, 7, 5, 3, 0, OH5, 0));
`ifdef SEC_CLAMP_EN
        load_q.push_back('{"load_075_clamped", mk(0, 0, 5, 9, 3, 0, OH5, 1)});
`else
        load_q.push_back('{"load_075_raw", mk(0, 0, 7, 5, 3, 0, OH5, 1)});
`endif
        pulse_start();
        step();
        snap("after_load_075", mk(0, 0, 0, 0, 0, 0, 10'd0, 0));

        step();
        done_req = 1'b1;
        step();
        step();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
- Receiving end of the keypad encoder interface (bcd[3:0] + valid_data).
- Turns held-key levels into single digit events and shifts them right-to-left into a 4-digit MM:SS entry buffer for the timer.
- Issues a one-cycle load pulse to the timer when start is pressed.
- Also decodes each accepted digit back to a 10-bit one-hot key image for display/debug.

Parameters:
- NUM_DIGITS, 4, entry buffer depth in BCD digits (fixed MM:SS layout; other values unsupported).
- MIN_HOLD, 1, cycles valid_data must stay low before the next press is accepted (release filter).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- bcd  input  4  digit code from keypad encoder; meaningful only while valid_data=1.
- valid_data  input  1  level, high while a key is held (low when encoder enablen=1).
- start  input  1  load request from control block.
- clear_entry  input  1  discard current entry.
- sec_ones  output  4  entry digit 0 (rightmost).
- sec_tens  output  4  entry digit 1.
- min_ones  output  4  entry digit 2.
- min_tens  output  4  entry digit 3.
- digit_count  output  3  accepted digits, 0..4.
- entry_full  output  1  digit_count==4.
- load  output  1  one-cycle pulse; digits valid during this cycle.
- key_onehot  output  10  one-hot of last accepted digit (bit n = digit n); 0 when none.

Behaviour:
- Reset (synchronous, active-high): all digits 0, digit_count 0, load 0, key_onehot 0, FSM -> IDLE. Reset wins over every other input, including mid-HELD.
- Priority per cycle: reset > clear_entry > start > key event.
- Key event = valid_data high while FSM in IDLE or ENTRY and bcd<=9.
  - bcd 10..15 is ignored: no shift, no state change.
- FSM states:
  - IDLE: no digits.
    - Key event: shift digit in, count=1, key_onehot updated, go HELD.
    - start ignored (no load with empty entry).
  - HELD: a key is down.
    - Further valid_data highs never shift.
    - After valid_data low for MIN_HOLD consecutive cycles, go ENTRY.
  - ENTRY: at least one digit, key released.
    - Key event with count<4: shift, count+1, go HELD.
    - Key event with count==4: no shift, count unchanged, still go HELD (the press is consumed).
  - LOAD: entered from HELD or ENTRY when start=1 and count>0.
    - load=1 for exactly this cycle; digits hold the entered value.
    - Next cycle: clear buffer, count 0, key_onehot 0, go IDLE.
- Shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=bcd. Registered; digits visible the cycle after the key event (1-cycle latency).
- clear_entry in any state: buffer, count and key_onehot zeroed, go IDLE; no load pulse.
- start and key event in the same cycle: start wins; the key is ignored.
- Digit 0 as the first press is a valid digit: count increments.
- Held key across load: FSM re-enters IDLE, and valid_data still high counts as a new event. The control block must assert start only with the keypad released; this is documented, not guarded.
- entry_full and digit_count are combinational from registered count.

Optional Feature:
- Macro SEC_CLAMP_EN.
- Defined: during the LOAD cycle, if {sec_tens,sec_ones} > 59, the outputs present sec_tens=5, sec_ones=9; the internal buffer is unchanged.
- Undefined: digits are passed raw (e.g. 0:75 is loaded as entered); the timer is responsible for normalisation.

Decomposition:
- Shared package keypad_pkg:
  - state enum {IDLE, HELD, ENTRY, LOAD};
  - constants BCD_W=4, KEYS=10, MAX_DIGIT=9, SEC_TENS_MAX=5.
- One natural sub-module: bcd_to_onehot (combinational 4->10 decoder, zero for codes >9). It generates key_onehot and is reused by the testbench as a golden model against the encoder.

Test Plan:
- Reset, then press 1,2,3,4 (valid_data high 3 cycles, low 2 each), then start -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=4, count 4, entry_full=1. load=1 for one cycle, then all zero, state IDLE.
- Hold key 7 high for 20 cycles -> exactly one shift: sec_ones=7, count=1, key_onehot=10'b0010000000.
- Enter 5 digits 9,8,7,6,5 -> buffer 9876, 5th press dropped, count stays 4.
- bcd=4'hC with valid_data=1 -> no change; start with count 0 -> no load pulse.
- Enter 3,2, then assert clear_entry with start high in the same cycle -> buffer zero, no load. Separately, assert reset mid-HELD -> all outputs 0 the next cycle.
- Enter 0,7,5 with SEC_CLAMP_EN defined, then start -> load cycle shows min_ones=0, sec_tens=5, sec_ones=9. Without the macro -> sec_tens=7, sec_ones=5.
